// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl: multi-cycle sequencer for RV32 SLL/SRL/SRA using an iterated shift datapath
// Ports: clk_i clock; rst_ni sync active-low reset; start_i/op_i/a_i/shamt_i request (op 00 SLL, 01 SRL, 10 SRA, 11 SLL);
// flush_i abort; ready_o can accept; busy_o op in flight (stall EX); done_o result valid; result_o held until next done.
// Optional macro SERIAL_SHIFT_FAST4_EN: shift 4 positions per cycle while at least 4 remain.
module serial_shift_ctrl #(
  parameter int N = 32,
  parameter int SHW = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [1:0]     op_i,
  input  logic [N-1:0]   a_i,
  input  logic [SHW-1:0] shamt_i,
  input  logic           flush_i,
  output logic           ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [N-1:0]   result_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t         state_q;
  logic [N-1:0]   data_q, data_d, sra_d, result_q;
  logic [SHW-1:0] count_q, count_d;
  logic [1:0]     op_q;
  logic [2:0]     amt;
`ifdef SERIAL_SHIFT_FAST4_EN
  assign amt = (count_q >= SHW'(4)) ? 3'd4 : 3'd1;
`else
  assign amt = 3'd1;
`endif
  assign sra_d   = $unsigned($signed(data_q) >>> amt);
  assign data_d  = op_q == 2'b01 ? data_q >> amt : op_q == 2'b10 ? sra_d : data_q << amt;
  assign count_d = count_q - SHW'(amt);
  assign ready_o  = state_q != SHIFT;
  assign busy_o   = state_q == SHIFT;
  assign done_o   = state_q == DONE;
  assign result_o = result_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      data_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else if (state_q != SHIFT && start_i) begin
      data_q  <= a_i;
      count_q <= shamt_i;
      op_q    <= op_i;
      state_q <= shamt_i == '0 ? DONE : SHIFT;
      if (shamt_i == '0) result_q <= a_i;
    end else if (state_q == SHIFT) begin
      data_q  <= data_d;
      count_q <= count_d;
      if (count_d == '0) begin
        state_q  <= DONE;
        result_q <= data_d;
      end
    end else begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_shift_ctrl.sv
// tb_serial_shift_ctrl: randomized and directed checks of serial_shift_ctrl against an arithmetic reference
module tb_serial_shift_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0;
  logic [4:0]  shamt = 0;
  logic        ready, busy, done;
  logic [31:0] result;
  int total = 0, bad = 0;

  serial_shift_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .shamt_i(shamt),
    .flush_i(flush), .ready_o(ready), .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_shift(input logic [1:0] o, input logic [31:0] x, input int s);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (o == 2'b01) return x >> s;
    if (o == 2'b10) return (x >> s) | (x[31] ? ~(ones >> s) : 32'h0);
    return x << s;
  endfunction

  function automatic int model_lat(input int s);
`ifdef SERIAL_SHIFT_FAST4_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s,
                       output int lat, output logic [31:0] res, output logic busy_ok);
    start = 1; op = o; a = x; shamt = s;
    tick();
    start = 0;
    lat = 1;
    busy_ok = 1;
    while (!done && lat < 100) begin
      if (!busy || ready) busy_ok = 0;
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; flush = 0;
    tick(); tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    rst_n = 1;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] res; logic bok;
    do_op(2'b00, 32'h0000_0001, 5'd31, lat, res, bok);
    total++; if (lat != model_lat(31)) begin bad++; $display("FAIL sll31_lat got=%0d want=%0d", lat, model_lat(31)); end
    total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL sll31_res got=%h want=80000000", res); end
    total++; if (!bok) begin bad++; $display("FAIL sll31_busy got=0 want=1"); end
    do_op(2'b10, 32'h8000_00F0, 5'd4, lat, res, bok);
    total++; if (lat != model_lat(4)) begin bad++; $display("FAIL sra4_lat got=%0d want=%0d", lat, model_lat(4)); end
    total++; if (res !== 32'hF800_000F) begin bad++; $display("FAIL sra4_res got=%h want=f800000f", res); end
    do_op(2'b01, 32'h8000_00F0, 5'd4, lat, res, bok);
    total++; if (res !== 32'h0800_000F) begin bad++; $display("FAIL srl4_res got=%h want=0800000f", res); end
    do_op(2'b11, 32'h0000_0003, 5'd2, lat, res, bok);
    total++; if (res !== 32'h0000_000C) begin bad++; $display("FAIL op11_res got=%h want=0000000c", res); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic bok;
    do_op(2'b01, 32'hDEAD_BEEF, 5'd0, lat, res, bok);
    total++; if (lat != 1) begin bad++; $display("FAIL sh0_lat got=%0d want=1", lat); end
    total++; if (res !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sh0_res got=%h want=deadbeef", res); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL done_ready got=%b want=1", ready); end
    do_op(2'b00, 32'h1234_5678, 5'd8, lat, res, bok);
    total++; if (lat != model_lat(8)) begin bad++; $display("FAIL b2b_lat got=%0d want=%0d", lat, model_lat(8)); end
    total++; if (res !== 32'h3456_7800) begin bad++; $display("FAIL b2b_res got=%h want=34567800", res); end
  endtask

  task automatic test_flush();
    logic [31:0] prev; logic seen;
    tick();
    prev = result;
    start = 1; op = 2'b00; a = 32'h0000_0005; shamt = 5'd10;
    tick();
    start = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_state got done=%b busy=%b want 0 0", done, busy); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", ready); end
    total++; if (result !== prev) begin bad++; $display("FAIL flush_result got=%h want=%h", result, prev); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL flush_nodone got=1 want=0"); end
    start = 1; flush = 1; op = 2'b01; a = 32'hFFFF_0000; shamt = 5'd0;
    tick();
    start = 0; flush = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin if (done || busy) seen = 1; tick(); end
    total++; if (seen) begin bad++; $display("FAIL flush_start_dropped got=1 want=0"); end
    total++; if (result !== prev) begin bad++; $display("FAIL flush_start_result got=%h want=%h", result, prev); end
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1; op = 2'b00; a = 32'h0000_0003; shamt = 5'd6;
    tick();
    start = 1; op = 2'b10; a = 32'h0; shamt = 5'd0;
    lat = 1;
    while (!done && lat < 100) begin tick(); start = 0; lat++; end
    total++; if (lat != model_lat(6)) begin bad++; $display("FAIL ignore_lat got=%0d want=%0d", lat, model_lat(6)); end
    total++; if (result !== 32'h0000_00C0) begin bad++; $display("FAIL ignore_res got=%h want=000000c0", result); end
  endtask

  task automatic test_reset_midop();
    start = 1; op = 2'b00; a = 32'hFFFF_FFFF; shamt = 5'd20;
    tick();
    start = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL midreset_ctrl got done=%b busy=%b ready=%b want 0 0 1", done, busy, ready); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h want=0", result); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, x; logic [1:0] o; logic [4:0] s; logic bok;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3)); x = $urandom; s = 5'($urandom_range(0, 31));
      do_op(o, x, s, lat, res, bok);
      total++; if (res !== model_shift(o, x, int'(s))) begin bad++; $display("FAIL rand_res op=%0d a=%h sh=%0d got=%h want=%h", o, x, s, res, model_shift(o, x, int'(s))); end
      total++; if (lat != model_lat(int'(s))) begin bad++; $display("FAIL rand_lat sh=%0d got=%0d want=%0d", s, lat, model_lat(int'(s))); end
      total++; if (!bok) begin bad++; $display("FAIL rand_busy sh=%0d got=0 want=1", s); end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_ignore_start();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
